eth_cmd_rx: RTL and testbench
=============================

ETH_CMD_RX -- requirements
Module: eth_cmd_rx

Interface
REQ-001 Parameter: MY_MAC, 48'h000A3501FEC0, destination MAC accepted besides broadcast FF:FF:FF:FF:FF:FF.
REQ-002 Parameter: CMD_ETYPE, 16'h88B5, EtherType identifying command frames.
REQ-003 clk  in  1  125 MHz RX byte clock, the only clock.
REQ-004 rstn  in  1  asynchronous, active-low reset.
REQ-005 rx_dv  in  1  byte valid from RGMII receiver; frame is a contiguous rx_dv-high run.
REQ-006 rx_er  in  1  PHY receive error, sampled with rx_dv.
REQ-007 rx_data  in  8  received byte, preamble onward.
REQ-008 cmd_valid  out  1  command available.
REQ-009 cmd_ready  in  1  consumer accepts; transfer when cmd_valid & cmd_ready.
REQ-010 cmd_opcode  out  8  payload byte 0.
REQ-011 cmd_arg  out  32  payload bytes 1..4, big-endian (byte 1 = MSB).
REQ-012 frm_ok_cnt / frm_err_cnt / frm_drop_cnt  out  16 each  saturating statistics.

Function
REQ-013 FSM states IDLE, PRE, HDR, PAY, CHECK, DROP; SHALL leave IDLE on rx_dv rising.
REQ-014 PRE: bytes 0x55 SHALL be skipped; 0xD5 SHALL enter HDR; any other byte, or more than 7 preamble bytes, SHALL enter DROP.
REQ-015 HDR: 14 bytes; destination not MY_MAC and not broadcast, or EtherType != CMD_ETYPE, SHALL enter DROP at the first mismatching byte (silent, no counter change).
REQ-016 PAY: payload bytes 0..4 SHALL load shadow opcode/arg registers; byte count SHALL saturate at 2047.
REQ-017 CRC-32 (IEEE, reflected, init 32'hFFFFFFFF) SHALL run over destination MAC through FCS inclusive, one byte per rx_dv cycle.
REQ-018 rx_dv falling in PAY SHALL enter CHECK for exactly one cycle.
REQ-019 CHECK: frame good iff CRC register == 32'hDEBB20E3, payload+FCS byte count in 50..1504, and rx_er never seen since SFD.
REQ-020 Good frame with cmd_valid low or accepted in the CHECK cycle: shadow SHALL copy to outputs, cmd_valid SHALL be 1 the cycle after CHECK, frm_ok_cnt +1.
REQ-021 Good frame while cmd_valid=1 and cmd_ready=0: outputs unchanged, frm_drop_cnt +1.
REQ-022 Bad frame after SFD with matching header: frm_err_cnt +1, outputs unchanged.
REQ-023 rx_er in PRE/HDR SHALL enter DROP; rx_dv falling in PRE/HDR (runt) SHALL return to IDLE with frm_err_cnt +1 only if in HDR.
REQ-024 DROP SHALL hold until rx_dv low, then IDLE; rx_dv low in any state SHALL never stall the FSM.
REQ-025 cmd_valid SHALL stay high with stable cmd_opcode/cmd_arg until handshake; it SHALL clear the cycle after handshake unless REQ-020 reloads in that same cycle.
REQ-026 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-027 Back-to-back frames with one idle (rx_dv low) cycle SHALL both be processed.

Reset
REQ-028 rstn low SHALL immediately force FSM=IDLE, cmd_valid=0, cmd_opcode=0, cmd_arg=0, all counters=0, CRC=32'hFFFFFFFF.
REQ-029 Reset release mid-frame SHALL start in IDLE and wait for the next rx_dv rising edge; the partial frame SHALL not be counted.

Structure
REQ-030 Shared package eth_pkg SHALL hold the FSM state enum, CRC init/residue constants, preamble/SFD bytes, and min/max length constants.
REQ-031 Sub-module crc32_d8 (8-bit parallel combinational next-CRC function) SHALL be the only sub-module, reusable by the TX path.

Verification
REQ-032 Valid frame to MY_MAC, EtherType 0x88B5, payload 01 DE AD BE EF + 41 zero pad, correct FCS -> cmd_valid=1, opcode 8'h01, arg 32'hDEADBEEF, frm_ok_cnt=1.
REQ-033 Same frame with last FCS byte XOR 8'h01 -> cmd_valid stays 0, frm_err_cnt=1.
REQ-034 Frame to MAC 02:00:00:00:00:01 -> no output change, all counters 0.
REQ-035 Two good frames (opcodes 0x01, 0x02), cmd_ready held 0 -> outputs show 0x01, frm_drop_cnt=1; ready pulse -> cmd_valid clears next cycle.
REQ-036 rstn asserted during payload byte 20, released, then one good frame opcode 0x07 -> only that command reported, frm_ok_cnt=1, frm_err_cnt=0.
REQ-037 rx_er pulsed on payload byte 10 of an otherwise good frame -> frm_err_cnt=1, cmd_valid 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and helpers for the Ethernet command path.
package eth_pkg;

  localparam int unsigned PAY_CNT_W = 11;
  localparam int unsigned HDR_IDX_W = 4;
  localparam int unsigned PRE_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    PAY,
    CHECK,
    DROP
  } eth_state_e;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam logic [PRE_CNT_W-1:0] MAX_PRE = 3'd7;

  localparam logic [HDR_IDX_W-1:0] MAC_BYTES   = 4'd6;
  localparam logic [HDR_IDX_W-1:0] ETYPE_HI_IX = 4'd12;
  localparam logic [HDR_IDX_W-1:0] ETYPE_LO_IX = 4'd13;

  localparam logic [PAY_CNT_W-1:0] MIN_LEN     = 11'd50;
  localparam logic [PAY_CNT_W-1:0] MAX_LEN     = 11'd1504;
  localparam logic [PAY_CNT_W-1:0] PAY_CNT_MAX = 11'd2047;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_cmd_rx_if.sv
// Command handshake bundle between the receiver (master) and its consumer.
interface eth_cmd_rx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [31:0] cmd_arg;

  modport master (output cmd_valid, output cmd_opcode, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_opcode, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected IEEE CRC-32 for one input byte.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc_c
);

  logic [31:0] w_c;

  // Fold the byte in LSB first, one polynomial step per bit.
  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
    end
    o_crc_c = w_c;
  end

endmodule

// File: rtl/eth_cmd_rx.sv
// Receives command frames from the RGMII byte stream, validates header,
// length and FCS, and presents opcode/argument on a valid/ready handshake.
module eth_cmd_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h000A3501FEC0,
  parameter logic [15:0] CMD_ETYPE = 16'h88B5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         rx_dv,
  input  logic         rx_er,
  input  logic [7:0]   rx_data,
  eth_cmd_rx_if.master cmd,
  output logic [15:0]  frm_ok_cnt,
  output logic [15:0]  frm_err_cnt,
  output logic [15:0]  frm_drop_cnt
);

  eth_state_e             r_state;
  logic                   r_dv_prev;
  logic [PRE_CNT_W-1:0]   r_pre_cnt;
  logic [HDR_IDX_W-1:0]   r_idx;
  logic                   r_me;
  logic                   r_bc;
  logic [31:0]            r_crc;
  logic                   r_err;
  logic [PAY_CNT_W-1:0]   r_pay_cnt;
  logic [7:0]             r_sh_op;
  logic [31:0]            r_sh_arg;
  logic                   r_cmd_valid;
  logic [7:0]             r_cmd_op;
  logic [31:0]            r_cmd_arg;
  logic [15:0]            r_ok_cnt;
  logic [15:0]            r_err_cnt;
  logic [15:0]            r_drop_cnt;

  logic [31:0]            w_crc_next;
  logic                   w_rise;
  logic [PRE_CNT_W-1:0]   w_pre_cnt_in;
  logic                   w_take_pre;
  eth_state_e             w_pre_next;
  logic [7:0]             w_mac_byte;
  logic                   w_me_hit;
  logic                   w_bc_hit;
  logic                   w_good;
  logic                   w_accept;

  crc32_d8 u_crc (
    .i_crc   (r_crc),
    .i_data  (rx_data),
    .o_crc_c (w_crc_next)
  );

  // A frame starts only on an rx_dv rising edge; CHECK may overlap the next
  // frame's first byte when frames are separated by a single idle cycle.
  assign w_rise       = rx_dv & ~r_dv_prev;
  assign w_pre_cnt_in = (r_state == PRE) ? r_pre_cnt : 3'd0;
  assign w_take_pre   = (((r_state == IDLE) || (r_state == CHECK)) && w_rise) ||
                        ((r_state == PRE) && rx_dv);

  // Preamble byte classification and destination MAC byte selection.
  always_comb begin
    w_pre_next = DROP;
    if (!rx_er) begin
      if (rx_data == SFD_BYTE) begin
        w_pre_next = HDR;
      end else if ((rx_data == PRE_BYTE) && (w_pre_cnt_in < MAX_PRE)) begin
        w_pre_next = PRE;
      end
    end
    case (r_idx[2:0])
      3'd0:    w_mac_byte = MY_MAC[47:40];
      3'd1:    w_mac_byte = MY_MAC[39:32];
      3'd2:    w_mac_byte = MY_MAC[31:24];
      3'd3:    w_mac_byte = MY_MAC[23:16];
      3'd4:    w_mac_byte = MY_MAC[15:8];
      3'd5:    w_mac_byte = MY_MAC[7:0];
      default: w_mac_byte = 8'h00;
    endcase
  end

  assign w_me_hit = r_me && (rx_data == w_mac_byte);
  assign w_bc_hit = r_bc && (rx_data == 8'hFF);
  assign w_good   = (r_crc == CRC_RESIDUE) && (r_pay_cnt >= MIN_LEN) &&
                    (r_pay_cnt <= MAX_LEN) && !r_err;
  assign w_accept = !r_cmd_valid || cmd.cmd_ready;

  // Receive FSM with datapath, handshake and statistics registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_dv_prev   <= 1'b1;
      r_pre_cnt   <= '0;
      r_idx       <= '0;
      r_me        <= 1'b0;
      r_bc        <= 1'b0;
      r_crc       <= CRC_INIT;
      r_err       <= 1'b0;
      r_pay_cnt   <= '0;
      r_sh_op     <= '0;
      r_sh_arg    <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_arg   <= '0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_dv_prev <= rx_dv;
      if (r_cmd_valid && cmd.cmd_ready) begin
        r_cmd_valid <= 1'b0;
      end

      case (r_state)
        IDLE: ;
        PRE: begin
          if (!rx_dv) begin
            r_state <= IDLE;
          end
        end
        HDR: begin
          if (!rx_dv) begin
            r_state   <= IDLE;
            r_err_cnt <= sat_inc16(r_err_cnt);
          end else if (rx_er) begin
            r_state <= DROP;
          end else begin
            r_crc <= w_crc_next;
            r_idx <= r_idx + 4'd1;
            if (r_idx < MAC_BYTES) begin
              r_me <= w_me_hit;
              r_bc <= w_bc_hit;
              if (!(w_me_hit || w_bc_hit)) begin
                r_state <= DROP;
              end
            end else if (r_idx == ETYPE_HI_IX) begin
              if (rx_data != CMD_ETYPE[15:8]) begin
                r_state <= DROP;
              end
            end else if (r_idx == ETYPE_LO_IX) begin
              r_state <= (rx_data == CMD_ETYPE[7:0]) ? PAY : DROP;
            end
          end
        end
        PAY: begin
          if (!rx_dv) begin
            r_state <= CHECK;
          end else begin
            r_crc <= w_crc_next;
            if (rx_er) begin
              r_err <= 1'b1;
            end
            if (r_pay_cnt != PAY_CNT_MAX) begin
              r_pay_cnt <= r_pay_cnt + 11'd1;
            end
            if (r_pay_cnt == 11'd0) begin
              r_sh_op <= rx_data;
            end else if (r_pay_cnt < 11'd5) begin
              r_sh_arg <= {r_sh_arg[23:0], rx_data};
            end
          end
        end
        CHECK: begin
          r_state <= IDLE;
          if (w_good) begin
            if (w_accept) begin
              r_cmd_valid <= 1'b1;
              r_cmd_op    <= r_sh_op;
              r_cmd_arg   <= r_sh_arg;
              r_ok_cnt    <= sat_inc16(r_ok_cnt);
            end else begin
              r_drop_cnt  <= sat_inc16(r_drop_cnt);
            end
          end else begin
            r_err_cnt <= sat_inc16(r_err_cnt);
          end
        end
        DROP: begin
          if (!rx_dv) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Preamble handling shared by IDLE, PRE and a CHECK overlapping a new frame.
      if (w_take_pre) begin
        r_state   <= w_pre_next;
        r_pre_cnt <= w_pre_cnt_in + 3'd1;
        if (w_pre_next == HDR) begin
          r_idx     <= '0;
          r_me      <= 1'b1;
          r_bc      <= 1'b1;
          r_crc     <= CRC_INIT;
          r_err     <= 1'b0;
          r_pay_cnt <= '0;
        end
      end
    end
  end

  assign cmd.cmd_valid  = r_cmd_valid;
  assign cmd.cmd_opcode = r_cmd_op;
  assign cmd.cmd_arg    = r_cmd_arg;
  assign frm_ok_cnt     = r_ok_cnt;
  assign frm_err_cnt    = r_err_cnt;
  assign frm_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_eth_cmd_rx.sv
// Directed bench for eth_cmd_rx with a scoreboard-driven command monitor.
module tb_eth_cmd_rx;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;
  logic [15:0] drop_cnt;

  eth_cmd_rx_if cmd_if ();

  eth_cmd_rx dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_dv        (rx_dv),
    .rx_er        (rx_er),
    .rx_data      (rx_data),
    .cmd          (cmd_if),
    .frm_ok_cnt   (ok_cnt),
    .frm_err_cnt  (err_cnt),
    .frm_drop_cnt (drop_cnt)
  );

  always #4 clk = ~clk;

  localparam logic [47:0] MAC_ME    = 48'h000A3501FEC0;
  localparam logic [47:0] MAC_BC    = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MAC_OTHER = 48'h020000000001;
  localparam logic [47:0] MAC_SRC   = 48'h021122334455;
  localparam int          NONE      = -100;

  int total = 0;
  int bad   = 0;
  int exp_ok   = 0;
  int exp_err  = 0;
  int exp_drop = 0;
  logic [39:0] exp_q[$];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) begin
      if ((r[0] ^ d[b]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_state(input string tag, input logic exp_valid);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(cmd_if.cmd_valid), 32'(exp_valid));
    chk({tag, "_ok"},    32'(ok_cnt),   32'(exp_ok));
    chk({tag, "_err"},   32'(err_cnt),  32'(exp_err));
    chk({tag, "_drop"},  32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic pulse_ready(input string tag);
    @(posedge clk);
    #1 cmd_if.cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_if.cmd_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_hs_clear"}, 32'(cmd_if.cmd_valid), 32'd0);
  endtask

  // Builds header+payload+FCS and streams it after npre preamble bytes and SFD.
  task automatic send_frame(input logic [47:0] dst, input logic [7:0] op, input logic [31:0] arg,
                            input int pad, input int npre, input bit bad_fcs,
                            input int er_pay, input int rst_pay, input int trunc);
    logic [7:0]  q[$];
    logic [31:0] c;
    logic [31:0] fcs;
    int n;
    for (int i = 0; i < 6; i++) q.push_back(dst[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) q.push_back(MAC_SRC[8*(5-i) +: 8]);
    q.push_back(8'h88);
    q.push_back(8'hB5);
    q.push_back(op);
    for (int i = 0; i < 4; i++) q.push_back(arg[8*(3-i) +: 8]);
    for (int i = 0; i < pad; i++) q.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = crc_byte(c, q[i]);
    fcs = ~c;
    for (int i = 0; i < 4; i++) q.push_back(fcs[8*i +: 8]);
    if (bad_fcs) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
    n = (trunc > 0) ? trunc : q.size();
    for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i - 14 == er_pay), q[i]);
      if (i - 14 == rst_pay)     rstn = 1'b0;
      if (i - 14 == rst_pay + 3) rstn = 1'b1;
    end
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic good_frame(input logic [47:0] dst, input logic [7:0] op, input logic [31:0] arg);
    send_frame(dst, op, arg, 41, 7, 1'b0, NONE, NONE, 0);
  endtask

  // Monitor: every newly presented command is popped from the scoreboard;
  // a held command must keep matching the last popped entry.
  initial begin : monitor
    logic        pv;
    logic        phs;
    logic [39:0] cur;
    pv  = 1'b0;
    phs = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        pv  = 1'b0;
        phs = 1'b0;
      end else begin
        if (cmd_if.cmd_valid && (!pv || phs)) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got op=%h arg=%h, required no command",
                     cmd_if.cmd_opcode, cmd_if.cmd_arg);
          end else begin
            cur = exp_q.pop_front();
            if ({cmd_if.cmd_opcode, cmd_if.cmd_arg} !== cur) begin
              bad++;
              $display("FAIL sb_cmd: got %h required %h", {cmd_if.cmd_opcode, cmd_if.cmd_arg}, cur);
            end
          end
        end else if (cmd_if.cmd_valid) begin
          total++;
          if ({cmd_if.cmd_opcode, cmd_if.cmd_arg} !== cur) begin
            bad++;
            $display("FAIL sb_hold: got %h required %h", {cmd_if.cmd_opcode, cmd_if.cmd_arg}, cur);
          end
        end
        pv  = cmd_if.cmd_valid;
        phs = cmd_if.cmd_valid && cmd_if.cmd_ready;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rstn = 1'b0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_data = 8'h00;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    check_state("rst", 1'b0);
    chk("rst_op",  32'(cmd_if.cmd_opcode), 32'd0);
    chk("rst_arg", cmd_if.cmd_arg, 32'd0);

    // Good frame to our MAC, consumer stalled: valid appears the cycle after CHECK.
    exp_q.push_back({8'h01, 32'hDEADBEEF});
    good_frame(MAC_ME, 8'h01, 32'hDEADBEEF);
    exp_ok = 1;
    @(posedge clk);
    @(posedge clk);
    check_state("t1", 1'b1);
    chk("t1_op",  32'(cmd_if.cmd_opcode), 32'h01);
    chk("t1_arg", cmd_if.cmd_arg, 32'hDEADBEEF);
    pulse_ready("t1");

    // Corrupted FCS.
    send_frame(MAC_ME, 8'h01, 32'hDEADBEEF, 41, 7, 1'b1, NONE, NONE, 0);
    exp_err = 1;
    idle(4);
    check_state("t2", 1'b0);

    // Foreign destination: silently ignored.
    good_frame(MAC_OTHER, 8'h09, 32'h12345678);
    idle(4);
    check_state("t3", 1'b0);

    // Broadcast with consumer ready.
    cmd_if.cmd_ready = 1'b1;
    exp_q.push_back({8'h03, 32'h11223344});
    good_frame(MAC_BC, 8'h03, 32'h11223344);
    exp_ok = 2;
    idle(4);
    check_state("t4", 1'b0);

    // Two back-to-back good frames while stalled: second is dropped.
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back({8'h01, 32'hA5A5A5A5});
    good_frame(MAC_ME, 8'h01, 32'hA5A5A5A5);
    good_frame(MAC_ME, 8'h02, 32'h5A5A5A5A);
    exp_ok = 3;
    exp_drop = 1;
    idle(4);
    check_state("t5", 1'b1);
    chk("t5_op",  32'(cmd_if.cmd_opcode), 32'h01);
    chk("t5_arg", cmd_if.cmd_arg, 32'hA5A5A5A5);
    pulse_ready("t5");

    // rx_er on payload byte 10.
    cmd_if.cmd_ready = 1'b1;
    send_frame(MAC_ME, 8'h04, 32'hCAFEF00D, 41, 7, 1'b0, 10, NONE, 0);
    exp_err = 2;
    idle(4);
    check_state("t6", 1'b0);

    // Runt ending inside the header.
    send_frame(MAC_ME, 8'h05, 32'h0, 41, 7, 1'b0, NONE, NONE, 5);
    exp_err = 3;
    idle(4);
    check_state("t7", 1'b0);

    // Eight preamble bytes: dropped silently.
    send_frame(MAC_ME, 8'h06, 32'h0, 41, 8, 1'b0, NONE, NONE, 0);
    idle(4);
    check_state("t8", 1'b0);

    // 49 payload+FCS bytes: one short of minimum.
    send_frame(MAC_ME, 8'h06, 32'h0, 40, 7, 1'b0, NONE, NONE, 0);
    exp_err = 4;
    idle(4);
    check_state("t9", 1'b0);

    // Reset during payload byte 20, released mid-frame, then a good frame.
    send_frame(MAC_ME, 8'h08, 32'h0, 41, 7, 1'b0, NONE, 20, 0);
    exp_ok = 0;
    exp_err = 0;
    exp_drop = 0;
    idle(4);
    check_state("t10a", 1'b0);
    chk("t10a_op",  32'(cmd_if.cmd_opcode), 32'd0);
    chk("t10a_arg", cmd_if.cmd_arg, 32'd0);
    exp_q.push_back({8'h07, 32'h0BADF00D});
    good_frame(MAC_ME, 8'h07, 32'h0BADF00D);
    exp_ok = 1;
    idle(4);
    check_state("t10b", 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
